emergency_preempt_arbiter: RTL and testbench

EMERGENCY_PREEMPT_ARBITER -- requirements
Module: emergency_preempt_arbiter

---
 rtl/emergency_preempt_arbiter.sv | 165 ++++++++++++++++
 tb/tb_emergency_preempt_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/emergency_preempt_arbiter.sv
// Emergency-vehicle preemption arbiter: debounces per-lane siren detectors and
// grants the intersection round-robin, one lane at a time, with all-red recovery.
module emergency_preempt_arbiter #(
    parameter int DEB_CYC     = 3,
    parameter int HOLD_CYC    = 8,
    parameter int MAX_HOLD    = 32,
    parameter int ACK_TO      = 6,
    parameter int RECOVER_CYC = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sound_sensors,
    input  logic       preempt_ack,
    output logic       preempt,
    output logic [3:0] grant_lane,
    output logic       ack_timeout,
    output logic [3:0] pending,
    output logic [7:0] grant_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CLEAR   = 2'd1;
    localparam logic [1:0] ST_GRANT   = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    localparam logic [3:0] DEB_LAST  = 4'(DEB_CYC - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [7:0] MAX_LAST  = 8'(MAX_HOLD - 1);
    localparam logic [7:0] ACK_LAST  = 8'(ACK_TO - 1);
    localparam logic [7:0] REC_LAST  = 8'(RECOVER_CYC - 1);

    logic [3:0][3:0] deb_cnt;
    logic [3:0][3:0] deb_cnt_nxt;
    logic [3:0]      req_db;
    logic [3:0]      req_db_nxt;
    logic [3:0]      req_rise;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] cnt;
    logic [1:0] ptr;
    logic [1:0] sel;
    logic [1:0] sel_cand;
    logic       timeout_evt;
    logic       enter_grant;
    logic [3:0] grant_mask;

    // A lane qualifies on its DEB_CYC-th consecutive high sample; any low sample
    // restarts the count, so a sensor high through reset still waits a full window.
    always_comb begin
        deb_cnt_nxt = deb_cnt;
        req_db_nxt  = '0;
        for (int i = 0; i < 4; i++) begin
            if (!sound_sensors[i]) begin
                deb_cnt_nxt[i] = '0;
                req_db_nxt[i]  = 1'b0;
            end else if (deb_cnt[i] == DEB_LAST) begin
                deb_cnt_nxt[i] = deb_cnt[i];
                req_db_nxt[i]  = 1'b1;
            end else begin
                deb_cnt_nxt[i] = deb_cnt[i] + 4'd1;
                req_db_nxt[i]  = 1'b0;
            end
        end
    end

    assign req_rise = req_db_nxt & ~req_db;

    // Round-robin search starts just after the last granted lane and wraps to it.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found    = 1'b0;
        sel_cand = ptr;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && pending[idx]) begin
                found    = 1'b1;
                sel_cand = idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        timeout_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|pending) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (preempt_ack) begin
                    state_nxt = ST_GRANT;
                end else if (cnt == ACK_LAST) begin
                    state_nxt   = ST_GRANT;
                    timeout_evt = 1'b1;
                end
            end
            ST_GRANT: begin
                if ((cnt >= HOLD_LAST && !req_db[sel]) || cnt == MAX_LAST)
                    state_nxt = ST_RECOVER;
            end
            ST_RECOVER: begin
                // Back-to-back grants skip CLEAR: the intersection is already all-red.
                if (cnt == REC_LAST) state_nxt = (|pending) ? ST_GRANT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign enter_grant = (state_nxt == ST_GRANT) && (state != ST_GRANT);
    assign grant_mask  = enter_grant ? (4'b0001 << sel_cand) : 4'b0000;

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt <= '0;
            req_db  <= '0;
            pending <= '0;
        end else begin
            deb_cnt <= deb_cnt_nxt;
            req_db  <= req_db_nxt;
            // A fresh qualification in the grant-entry cycle stays pending.
            pending <= (pending & ~grant_mask) | req_rise;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ptr         <= 2'd3;
            sel         <= 2'd0;
            grant_count <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == ST_IDLE) cnt <= '0;
            else                                         cnt <= cnt + 8'd1;
            if (enter_grant) begin
                sel <= sel_cand;
                ptr <= sel_cand;
                if (grant_count != 8'hFF) grant_count <= grant_count + 8'd1;
            end
        end
    end

    // Outputs are registered from the next-state decode, so they change on the
    // same edge as the state itself and reset clears them asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            preempt     <= 1'b0;
            grant_lane  <= '0;
            ack_timeout <= 1'b0;
        end else begin
            preempt     <= (state_nxt != ST_IDLE);
            ack_timeout <= timeout_evt;
            if (state_nxt == ST_GRANT)
                grant_lane <= 4'b0001 << (enter_grant ? sel_cand : sel);
            else
                grant_lane <= '0;
        end
    end

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// Directed bench for emergency_preempt_arbiter with default parameters
// (DEB_CYC=3, HOLD_CYC=8, MAX_HOLD=32, ACK_TO=6, RECOVER_CYC=2).
module tb_emergency_preempt_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] sound_sensors;
    logic       preempt_ack;
    logic       preempt;
    logic [3:0] grant_lane;
    logic       ack_timeout;
    logic [3:0] pending;
    logic [7:0] grant_count;

    int checks = 0;
    int errors = 0;

    emergency_preempt_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sound_sensors(sound_sensors),
        .preempt_ack  (preempt_ack),
        .preempt      (preempt),
        .grant_lane   (grant_lane),
        .ack_timeout  (ack_timeout),
        .pending      (pending),
        .grant_count  (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in a GRANT cycle already counted as 'start'; returns total GRANT length.
    task automatic measure_grant(input int start, output int n);
        n = start;
        tick();
        while (grant_lane != 4'b0 && n < 300) begin
            n++;
            tick();
        end
    endtask

    // Called in the first all-red cycle after a grant; returns RECOVER length.
    task automatic measure_recover(output int n);
        n = 0;
        while (preempt && grant_lane == 4'b0 && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (preempt && n < 200) begin
            n++;
            tick();
        end
        check(tag, preempt, 1'b0);
    endtask

    initial begin
        int g;
        int r;
        int c;
        logic seen_to;

        reset_n       = 1'b0;
        sound_sensors = 4'b0;
        preempt_ack   = 1'b0;
        tick();
        tick();
        check("rst_preempt", preempt, 1'b0);
        check("rst_grant", grant_lane, 4'b0);
        check("rst_timeout", ack_timeout, 1'b0);
        check("rst_pending", pending, 4'b0);
        check("rst_count", grant_count, 8'd0);
        reset_n = 1'b1;

        // Lane 0 held, ack two cycles after preempt, sensor drops after 3 GRANT cycles.
        sound_sensors = 4'b0001;
        tick();
        tick();
        check("t1_pend_early", pending, 4'b0000);
        tick();
        check("t1_pend", pending, 4'b0001);
        check("t1_preempt_lo", preempt, 1'b0);
        tick();
        check("t1_clear_pre", preempt, 1'b1);
        check("t1_clear_gl", grant_lane, 4'b0);
        tick();
        preempt_ack = 1'b1;
        tick();
        check("t1_grant", grant_lane, 4'b0001);
        check("t1_count", grant_count, 8'd1);
        check("t1_pend_clr", pending, 4'b0000);
        check("t1_no_to", ack_timeout, 1'b0);
        preempt_ack = 1'b0;
        tick();
        tick();
        sound_sensors = 4'b0000;
        measure_grant(3, g);
        check("t1_grant_len", g, 8);
        measure_recover(r);
        check("t1_recover_len", r, 2);
        check("t1_idle", preempt, 1'b0);

        // Two-cycle glitch on lane 2 must not qualify.
        sound_sensors = 4'b0100;
        tick();
        tick();
        sound_sensors = 4'b0000;
        repeat (4) tick();
        check("t2_pend", pending, 4'b0000);
        check("t2_preempt", preempt, 1'b0);

        // Lanes 1 and 3 qualify together: lane 1 for MAX_HOLD, then lane 3 without CLEAR.
        sound_sensors = 4'b1010;
        repeat (3) tick();
        check("t3_pend", pending, 4'b1010);
        tick();
        preempt_ack = 1'b1;
        tick();
        check("t3_grant1", grant_lane, 4'b0010);
        check("t3_pend1", pending, 4'b1000);
        preempt_ack = 1'b0;
        measure_grant(1, g);
        check("t3_grant_len", g, 32);
        measure_recover(r);
        check("t3_recover_len", r, 2);
        check("t3_grant3", grant_lane, 4'b1000);
        check("t3_preempt", preempt, 1'b1);
        check("t3_pend3", pending, 4'b0000);
        check("t3_count", grant_count, 8'd3);
        sound_sensors = 4'b0000;
        wait_idle("t3_idle");

        // Lane 2 with ack tied low: six CLEAR cycles then a single timeout pulse.
        sound_sensors = 4'b0100;
        repeat (3) tick();
        check("t4_pend", pending, 4'b0100);
        tick();
        c = 0;
        seen_to = 1'b0;
        while (grant_lane == 4'b0 && c < 50) begin
            if (ack_timeout) seen_to = 1'b1;
            c++;
            tick();
        end
        check("t4_clear_len", c, 6);
        check("t4_early_to", seen_to, 1'b0);
        check("t4_to_pulse", ack_timeout, 1'b1);
        check("t4_grant", grant_lane, 4'b0100);
        tick();
        check("t4_to_drop", ack_timeout, 1'b0);
        sound_sensors = 4'b0000;
        wait_idle("t4_idle");
        check("t4_count", grant_count, 8'd4);

        // Lane 0 again; reset during GRANT cycle 4 clears outputs before the next edge.
        sound_sensors = 4'b0001;
        repeat (3) tick();
        tick();
        preempt_ack = 1'b1;
        tick();
        check("t5_grant", grant_lane, 4'b0001);
        preempt_ack = 1'b0;
        tick();
        tick();
        sound_sensors = 4'b0000;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_gl", grant_lane, 4'b0);
        check("t5_async_pre", preempt, 1'b0);
        check("t5_async_cnt", grant_count, 8'd0);
        check("t5_async_pend", pending, 4'b0);

        // Sensor already high when reset releases still needs three samples.
        sound_sensors = 4'b0001;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("t6_pend_wait", pending, 4'b0000);
        tick();
        check("t6_pend", pending, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
